// File: rtl/gpr_pkg.sv
// Shared constants and types for the general-purpose register file and its
// write-back path.
package gpr_pkg;

  // Register file geometry.
  localparam int unsigned GPR_AW = 5;
  localparam int unsigned GPR_DW = 32;
  localparam logic [4:0]  GPR_ZERO = 5'd0;

  // Write-back source slots on the arbiter request vector.
  typedef enum logic [2:0] {
    WB_SRC_ALU  = 3'd0,
    WB_SRC_MEM  = 3'd1,
    WB_SRC_LINK = 3'd2
  } wb_src_e;

  // Width of a binary index over n requesters (at least one bit).
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpr_wb_arb_rr_pick.sv
// rr_pick: combinational rotating-priority picker. Scans the request vector
// starting at index 'start', wrapping around, and returns the first set
// request as a one-hot grant plus its binary index. A constant start of 0
// gives plain lowest-index-first priority.
module rr_pick
  import gpr_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = idx_bits(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   win
);

  // First set request at or after 'start', wrapping modulo NREQ.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(start) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb: write-back arbiter for the 32x32 register file. Grants one
// source per cycle, registers its index/data and drives the file's single
// write port one cycle later. Writes to register 0 are granted but never
// assert rw.
// Build option: define GPR_WB_RR_EN for round-robin priority; otherwise the
// lowest-index requester always wins and no priority pointer exists.
module gpr_wb_arb
  import gpr_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = GPR_DW,
  parameter int unsigned AW   = GPR_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               rw,
  output logic [AW-1:0]      WriteReg,
  output logic [DW-1:0]      WriteData
);

  localparam int unsigned IW = idx_bits(NREQ);

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win;
  logic [IW-1:0]   start;
  logic            xfer;
  logic [AW-1:0]   sel_reg;
  logic [DW-1:0]   sel_data;

`ifdef GPR_WB_RR_EN
  localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

  logic [IW-1:0] ptr;

  // Search begins one past the last winner, wrapping at NREQ.
  always_comb begin
    start = (ptr == PTR_RST) ? '0 : ptr + 1'b1;
  end

  // Pointer follows the most recent transfer; reset gives source 0 priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PTR_RST;
    end else if (xfer) begin
      ptr <= win;
    end
  end
`else
  // Fixed priority: always scan from source 0.
  always_comb begin
    start = '0;
  end
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .start (start),
    .grant (grant),
    .win   (win)
  );

  // Grant is suppressed by hold and reset; a transfer is any acked request.
  always_comb begin
    ack  = (rst || hold) ? '0 : grant;
    xfer = |ack;
  end

  // Winner's index and data, selected by binary winner index so the data
  // path never feeds back into ack.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_reg  = req_reg[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Output register: capture on transfer, drop rw otherwise; reg 0 is filtered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw        <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (xfer) begin
      rw        <= (sel_reg != AW'(GPR_ZERO));
      WriteReg  <= sel_reg;
      WriteData <= sel_data;
    end else begin
      rw <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Self-checking bench for gpr_wb_arb (NREQ=3). Directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_gpr_wb_arb;

  localparam int N = 3;

  logic        clk;
  logic        rst;
  logic        hold;
  logic [2:0]  req;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [2:0]  ack;
  logic        rw;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int          m_ptr;
  bit          m_known;
  logic        m_rw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [2:0]  last_ack;

  // Register file driven by the arbiter outputs.
  logic [31:0] rf [32];

  gpr_wb_arb #(
    .NREQ (3),
    .DW   (32),
    .AW   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req       (req),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .ack       (ack),
    .rw        (rw),
    .WriteReg  (WriteReg),
    .WriteData (WriteData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rw === 1'b1) rf[WriteReg] <= WriteData;
  end

  function automatic int model_pick(input logic [2:0] r, input int p);
`ifdef GPR_WB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [14:0] regs(input logic [4:0] a, b, c);
    return {c, b, a};
  endfunction

  function automatic logic [95:0] datas(input logic [31:0] a, b, c);
    return {c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check ack and outputs, advance the model.
  task automatic cyc(input logic r, input logic h, input logic [2:0] rq,
                     input logic [14:0] rr, input logic [95:0] rd);
    int         w;
    logic [2:0] e_ack;
    rst = r; hold = h; req = rq; req_reg = rr; req_data = rd;
    #1;
    w = (r || h) ? -1 : model_pick(rq, m_ptr);
    e_ack = (w < 0) ? 3'b000 : 3'(1 << w);
    last_ack = ack;
    chk("ack", {29'b0, ack}, {29'b0, e_ack});
    if (m_known) begin
      chk("rw", {31'b0, rw}, {31'b0, m_rw});
      chk("WriteReg", {27'b0, WriteReg}, {27'b0, m_reg});
      chk("WriteData", WriteData, m_data);
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1;
      m_rw = 1'b0; m_reg = '0; m_data = '0; m_ptr = N - 1;
    end else if (w >= 0) begin
      m_reg  = rr[w*5 +: 5];
      m_data = rd[w*32 +: 32];
      m_rw   = (m_reg != 5'd0);
      m_ptr  = w;
    end else begin
      m_rw = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [2:0] exp_ack;
    m_known = 1'b0; m_ptr = N - 1; m_rw = 1'b0; m_reg = '0; m_data = '0;
    rst = 1'b1; hold = 1'b0; req = '0; req_reg = '0; req_data = '0;

    // Reset state.
    cyc(1, 0, 3'b000, '0, '0);
    cyc(1, 0, 3'b000, '0, '0);
    chk("rst_rw", {31'b0, rw}, 32'd0);
    chk("rst_wreg", {27'b0, WriteReg}, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);

    // Single request from source 0.
    cyc(0, 0, 3'b001, regs(5'd5, 5'd0, 5'd0), datas(32'h1234ABCD, 0, 0));
    chk("t1_ack", {29'b0, last_ack}, 32'd1);
    chk("t1_rw", {31'b0, rw}, 32'd1);
    chk("t1_wreg", {27'b0, WriteReg}, 32'd5);
    chk("t1_wdata", WriteData, 32'h1234ABCD);
    cyc(0, 0, 3'b000, '0, '0);
    chk("t1_rw_drop", {31'b0, rw}, 32'd0);

    // Fairness with all three requesting.
    cyc(1, 0, 3'b000, '0, '0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 3'b111, regs(5'd1, 5'd2, 5'd3), datas($urandom, $urandom, $urandom));
`ifdef GPR_WB_RR_EN
      exp_ack = 3'(1 << (k % 3));
`else
      exp_ack = 3'b001;
`endif
      chk("rr_seq", {29'b0, last_ack}, {29'b0, exp_ack});
    end

    // Register 0 write: acked, consumes the slot, never asserts rw.
    cyc(0, 0, 3'b010, regs(5'd1, 5'd0, 5'd3), datas(32'h1, 32'hFFFFFFFF, 32'h3));
    chk("r0_ack", {29'b0, last_ack}, 32'd2);
    chk("r0_rw", {31'b0, rw}, 32'd0);
    cyc(0, 0, 3'b111, regs(5'd4, 5'd5, 5'd6), datas(32'h4, 32'h5, 32'h6));
`ifdef GPR_WB_RR_EN
    chk("r0_next", {29'b0, last_ack}, 32'd4);
`else
    chk("r0_next", {29'b0, last_ack}, 32'd1);
`endif

    // Hold: in-flight write completes, no grants while held.
    cyc(1, 0, 3'b000, '0, '0);
    cyc(0, 0, 3'b001, regs(5'd4, 5'd0, 5'd0), datas(32'hCAFE, 0, 0));
    chk("hold_rw_t1", {31'b0, rw}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 3'b110, regs(5'd0, 5'd8, 5'd9), datas(0, 32'h8, 32'h9));
      chk("hold_ack", {29'b0, last_ack}, 32'd0);
      chk("hold_rw", {31'b0, rw}, 32'd0);
    end
    cyc(0, 0, 3'b110, regs(5'd0, 5'd8, 5'd9), datas(0, 32'h8, 32'h9));
    chk("hold_release", {29'b0, last_ack}, 32'd2);

    // Reset mid-operation discards the grant.
    cyc(1, 0, 3'b010, regs(5'd0, 5'd9, 5'd0), datas(0, 32'h99, 0));
    chk("rstmid_ack", {29'b0, last_ack}, 32'd0);
    chk("rstmid_rw", {31'b0, rw}, 32'd0);
    chk("rstmid_wreg", {27'b0, WriteReg}, 32'd0);
    chk("rstmid_wdata", WriteData, 32'd0);
    cyc(0, 0, 3'b111, regs(5'd1, 5'd2, 5'd3), datas(1, 2, 3));
    chk("rstmid_next", {29'b0, last_ack}, 32'd1);

    // Same-index collision: last granted value wins.
    cyc(1, 0, 3'b000, '0, '0);
    cyc(0, 0, 3'b011, regs(5'd7, 5'd7, 5'd0), datas(32'hA, 32'hB, 0));
    chk("col_ack0", {29'b0, last_ack}, 32'd1);
    chk("col_rw0", {31'b0, rw}, 32'd1);
    cyc(0, 0, 3'b010, regs(5'd7, 5'd7, 5'd0), datas(32'hA, 32'hB, 0));
    chk("col_ack1", {29'b0, last_ack}, 32'd2);
    chk("col_rw1", {31'b0, rw}, 32'd1);
    cyc(0, 0, 3'b000, '0, '0);
    cyc(0, 0, 3'b000, '0, '0);
    chk("col_rf7", rf[7], 32'hB);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [14:0] rr;
      rr = 15'($urandom);
      if ($urandom_range(0, 3) == 0) rr[4:0] = 5'd0;
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
          3'($urandom), rr, datas($urandom, $urandom, $urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
